// File: rtl/avg_pool_unit_float16.sv
// avg_pool_unit_float16
//   Streaming FP16 (IEEE binary16) average-pooling lane. One sample is
//   consumed on every rising clock edge while rst is high. Each run of
//   data_num consecutive samples forms a window; its mean is written to
//   avg_pool_result one cycle after the window's last sample is captured.
//
// Stream semantics: there is no valid/stall input. Every rising edge with
//   rst=1 consumes avg_input_data as the next sample. result_ready is a
//   sticky "a result exists" flag (not a per-result strobe). It rises with
//   the first completed window and stays high until reset.
//   avg_pool_result holds its value until the next window completes.
//
// Ports:
//   clk             rising-edge clock
//   rst             synchronous active-low reset (0: reset, 1: run)
//   avg_input_data  FP16 sample, captured every edge while rst=1
//   data_num        window length (0 behaves as 1), latched at sample 1
//   result_ready    1 once at least one window average is available
//   avg_pool_result FP16 mean of the most recently completed window
module avg_pool_unit_float16 #(
  parameter int DATA_WIDTH     = 16,
  parameter int DATA_NUM_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_WIDTH-1:0]     avg_input_data,
  input  logic [DATA_NUM_WIDTH-1:0] data_num,
  output logic                      result_ready,
  output logic [DATA_WIDTH-1:0]     avg_pool_result
);

  localparam int NW = DATA_NUM_WIDTH;
  localparam logic [NW-1:0] N_ONE  = NW'(1);
  localparam logic [NW-1:0] N_ZERO = '0;

  // Round-to-nearest-even and pack. The significand arrives with its leading
  // one in sig[10]. exp_in is the biased exponent before the rounding carry.
  // Out-of-range exponents become inf (too large) or +0 (subnormal flush).
  function automatic logic [15:0] fp16_pack(input logic sign, input int exp_in,
                                            input logic [10:0] sig,
                                            input logic guard, input logic sticky);
    int         e;
    logic       up;
    logic [11:0] rm;
    e  = exp_in;
    up = guard & (sticky | sig[0]);
    rm = {1'b0, sig} + {11'b0, up};
    if (rm[11]) begin
      rm = {1'b0, rm[11:1]};
      e  = e + 1;
    end
    if (e >= 31) return {sign, 5'h1f, 10'h000};
    if (e <= 0)  return 16'h0000;
    return {sign, e[4:0], rm[9:0]};
  endfunction

  // FP16 add. Subnormal inputs count as zero. NaN or (+inf)+(-inf) gives the
  // canonical NaN. This also lets specials carry through the running sum
  // without any separate flags.
  function automatic logic [15:0] fp16_add(input logic [15:0] a, input logic [15:0] b);
    logic        sa, sb, s_big, s_small;
    logic [4:0]  ea, eb, e_big, e_small, d;
    logic [10:0] sig_a, sig_b, sig_big, sig_small;
    logic [31:0] tmp;
    logic [13:0] al_big, al_small, m;
    logic [14:0] r;
    logic        a_nan, b_nan, a_inf, b_inf, found;
    int          lz, e;
    sa = a[15]; ea = a[14:10];
    sb = b[15]; eb = b[14:10];
    a_nan = (ea == 5'h1f) && (a[9:0] != 10'h0);
    b_nan = (eb == 5'h1f) && (b[9:0] != 10'h0);
    a_inf = (ea == 5'h1f) && (a[9:0] == 10'h0);
    b_inf = (eb == 5'h1f) && (b[9:0] == 10'h0);
    if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) return 16'h7e00;
    if (a_inf) return {sa, 5'h1f, 10'h000};
    if (b_inf) return {sb, 5'h1f, 10'h000};
    sig_a = (ea == 5'h0) ? 11'h0 : {1'b1, a[9:0]};
    sig_b = (eb == 5'h0) ? 11'h0 : {1'b1, b[9:0]};
    // Larger magnitude goes first so subtraction never goes negative.
    if ({ea, sig_a} >= {eb, sig_b}) begin
      s_big = sa; e_big = ea; sig_big = sig_a;
      s_small = sb; e_small = eb; sig_small = sig_b;
    end else begin
      s_big = sb; e_big = eb; sig_big = sig_b;
      s_small = sa; e_small = ea; sig_small = sig_a;
    end
    d = e_big - e_small;
    // Three guard positions; everything shifted below them folds into a sticky LSB.
    tmp      = {sig_small, 21'b0} >> d;
    al_small = tmp[31:18] | {13'b0, |tmp[17:0]};
    al_big   = {sig_big, 3'b000};
    if (s_big == s_small) r = {1'b0, al_big} + {1'b0, al_small};
    else                  r = {1'b0, al_big} - {1'b0, al_small};
    if (r == 15'h0) return 16'h0000;
    if (r[14]) begin
      m = r[14:1] | {13'b0, r[0]};
      e = int'(e_big) + 1;
    end else begin
      lz    = 0;
      found = 1'b0;
      for (int i = 13; i >= 0; i--) begin
        if (!found && r[i]) begin
          lz    = 13 - i;
          found = 1'b1;
        end
      end
      m = r[13:0] << lz;
      e = int'(e_big) - lz;
    end
    return fp16_pack(s_big, e, m[13:3], m[2], |m[1:0]);
  endfunction

  // FP16 divide by an unsigned integer window length n (n >= 1).
  // n is normalised to 1.xxx * 2^p. The quotient carries 18+ bits after the
  // leading one, and the remainder feeds the sticky bit.
  function automatic logic [15:0] fp16_div(input logic [15:0] s, input logic [NW-1:0] n);
    logic [4:0]     es;
    logic [10:0]    sig;
    logic [NW-1:0]  n_sig;
    logic [18+NW:0] num, q, rem;
    int             p;
    es = s[14:10];
    if ((es == 5'h1f) && (s[9:0] != 10'h0)) return 16'h7e00;
    if (es == 5'h1f) return {s[15], 5'h1f, 10'h000};
    if (es == 5'h0)  return 16'h0000;
    sig = {1'b1, s[9:0]};
    p = 0;
    for (int i = 0; i < NW; i++) begin
      if (n[i]) p = i;
    end
    n_sig = n << (NW - 1 - p);
    num   = {sig, {(8 + NW){1'b0}}};
    q     = num / {{19{1'b0}}, n_sig};
    rem   = num % {{19{1'b0}}, n_sig};
    // Ratio sig/n_sig lies in (0.5, 2): leading one is at bit 19 or bit 18.
    if (q[19])
      return fp16_pack(s[15], int'(es) - p, q[19:9], q[8], (|q[7:0]) | (rem != '0));
    return fp16_pack(s[15], int'(es) - p - 1, q[18:8], q[7], (|q[6:0]) | (rem != '0));
  endfunction

  logic [15:0]   acc;
  logic [15:0]   sum_reg;
  logic [NW-1:0] count;
  logic [NW-1:0] n_lat;
  logic [NW-1:0] n_reg;
  logic          div_valid;

  logic [NW-1:0] n_cur;
  logic [15:0]   sum_next;

  // count==0 marks sample 1: the window length is taken live from data_num
  // there, and from the latched copy for the rest of the window.
  always_comb begin
    n_cur    = n_lat;
    sum_next = avg_input_data;
    if (count == N_ZERO) begin
      n_cur = (data_num == N_ZERO) ? N_ONE : data_num;
    end else begin
      sum_next = fp16_add(acc, avg_input_data);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc             <= 16'h0000;
      sum_reg         <= 16'h0000;
      count           <= N_ZERO;
      n_lat           <= N_ZERO;
      n_reg           <= N_ZERO;
      div_valid       <= 1'b0;
      result_ready    <= 1'b0;
      avg_pool_result <= '0;
    end else begin
      n_lat     <= n_cur;
      div_valid <= 1'b0;
      if (count == n_cur - N_ONE) begin
        // Last sample: hand the sum to the divide stage and restart the
        // window so the next edge is sample 1 with no bubble.
        sum_reg   <= sum_next;
        n_reg     <= n_cur;
        div_valid <= 1'b1;
        count     <= N_ZERO;
      end else begin
        acc   <= sum_next;
        count <= count + N_ONE;
      end
      if (div_valid) begin
        avg_pool_result <= DATA_WIDTH'(fp16_div(sum_reg, n_reg));
        result_ready    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_avg_pool_unit_float16.sv
// Directed bench for avg_pool_unit_float16. Inputs change on the falling
// edge and outputs are sampled there too, half a cycle after the capturing
// rising edge.
module tb_avg_pool_unit_float16;

  logic        clk;
  logic        rst;
  logic [15:0] avg_input_data;
  logic [7:0]  data_num;
  logic        result_ready;
  logic [15:0] avg_pool_result;

  int checks;
  int errors;

  avg_pool_unit_float16 #(.DATA_WIDTH(16), .DATA_NUM_WIDTH(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .avg_input_data  (avg_input_data),
    .data_num        (data_num),
    .result_ready    (result_ready),
    .avg_pool_result (avg_pool_result)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Caller sits at a falling edge. Two reset edges, then rst released at a
  // falling edge so the next drive() supplies sample 1.
  task automatic do_reset();
    rst = 1'b0;
    avg_input_data = 16'h0000;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Present one sample and return at the falling edge after it is captured.
  task automatic drive(input logic [15:0] x);
    avg_input_data = x;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    avg_input_data = 16'h1234;
    data_num = 8'd4;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (result_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready: got %b want 0", result_ready);
    end
    checks++;
    if (avg_pool_result !== 16'h0000) begin
      errors++; $display("FAIL reset_result: got %h want 0000", avg_pool_result);
    end
    rst = 1'b1;
  endtask

  // Nine identical samples, data_num=9: mean equals the sample.
  task automatic test_constant_window();
    logic [15:0] vals [3];
    vals[0] = 16'h4200; vals[1] = 16'h3c00; vals[2] = 16'h4000;
    for (int v = 0; v < 3; v++) begin
      do_reset();
      data_num = 8'd9;
      for (int i = 0; i < 9; i++) drive(vals[v]);
      checks++;
      if (result_ready !== 1'b0) begin
        errors++; $display("FAIL const_latency[%0d]: ready got %b want 0", v, result_ready);
      end
      drive(16'h0000);
      checks++;
      if (result_ready !== 1'b1 || avg_pool_result !== vals[v]) begin
        errors++;
        $display("FAIL const_mean[%0d]: got ready=%b %h want ready=1 %h",
                 v, result_ready, avg_pool_result, vals[v]);
      end
    end
  endtask

  // Mixed windows: exact means, negatives, and two rounded thirds.
  task automatic test_mean_patterns();
    logic [15:0] vec [6][4];
    logic [7:0]  n   [6];
    logic [15:0] exp_v [6];
    vec[0] = '{16'h3c00, 16'h4200, 16'h3c00, 16'h4200}; n[0] = 8'd4; exp_v[0] = 16'h4000;
    vec[1] = '{16'h4000, 16'h4400, 16'h4400, 16'h4000}; n[1] = 8'd4; exp_v[1] = 16'h4200;
    vec[2] = '{16'hbc00, 16'hbc00, 16'h3c00, 16'h4200}; n[2] = 8'd4; exp_v[2] = 16'h3800;
    vec[3] = '{16'h3c00, 16'h3c00, 16'h3c00, 16'h0000}; n[3] = 8'd3; exp_v[3] = 16'h3c00;
    // 4/3 = 1.0101010101|01.. -> round down
    vec[4] = '{16'h3c00, 16'h3c00, 16'h4000, 16'h0000}; n[4] = 8'd3; exp_v[4] = 16'h3d55;
    // 5/3 = 1.1010101010|10.. -> round up
    vec[5] = '{16'h3c00, 16'h3c00, 16'h4200, 16'h0000}; n[5] = 8'd3; exp_v[5] = 16'h3eab;
    for (int t = 0; t < 6; t++) begin
      do_reset();
      data_num = n[t];
      for (int i = 0; i < int'(n[t]); i++) drive(vec[t][i]);
      drive(16'h0000);
      checks++;
      if (result_ready !== 1'b1 || avg_pool_result !== exp_v[t]) begin
        errors++;
        $display("FAIL mean_pattern[%0d]: got ready=%b %h want ready=1 %h",
                 t, result_ready, avg_pool_result, exp_v[t]);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    data_num = 8'd4;
    for (int i = 0; i < 4; i++) drive(16'h4000);
    drive(16'h4400);
    checks++;
    if (result_ready !== 1'b1 || avg_pool_result !== 16'h4000) begin
      errors++; $display("FAIL b2b_first: got ready=%b %h want ready=1 4000", result_ready, avg_pool_result);
    end
    for (int i = 0; i < 3; i++) begin
      drive(16'h4400);
      checks++;
      if (result_ready !== 1'b1 || avg_pool_result !== 16'h4000) begin
        errors++; $display("FAIL b2b_hold[%0d]: got ready=%b %h want ready=1 4000", i, result_ready, avg_pool_result);
      end
    end
    drive(16'h0000);
    checks++;
    if (result_ready !== 1'b1 || avg_pool_result !== 16'h4400) begin
      errors++; $display("FAIL b2b_second: got ready=%b %h want ready=1 4400", result_ready, avg_pool_result);
    end
  endtask

  task automatic test_data_num_change();
    do_reset();
    data_num = 8'd4;
    drive(16'h3c00);
    data_num = 8'd2;
    drive(16'h3c00);
    drive(16'h3c00);
    checks++;
    if (result_ready !== 1'b0) begin
      errors++; $display("FAIL dn_change_early: ready got %b want 0", result_ready);
    end
    drive(16'h3c00);
    checks++;
    if (result_ready !== 1'b0) begin
      errors++; $display("FAIL dn_change_pending: ready got %b want 0", result_ready);
    end
    drive(16'h4000);
    checks++;
    if (result_ready !== 1'b1 || avg_pool_result !== 16'h3c00) begin
      errors++; $display("FAIL dn_change_win1: got ready=%b %h want ready=1 3c00", result_ready, avg_pool_result);
    end
    drive(16'h4000);
    checks++;
    if (avg_pool_result !== 16'h3c00) begin
      errors++; $display("FAIL dn_change_hold: got %h want 3c00", avg_pool_result);
    end
    drive(16'h4400);
    checks++;
    if (avg_pool_result !== 16'h4000) begin
      errors++; $display("FAIL dn_change_win2: got %h want 4000", avg_pool_result);
    end
  endtask

  task automatic test_reset_mid_window();
    do_reset();
    data_num = 8'd4;
    for (int i = 0; i < 4; i++) drive(16'h4000);
    drive(16'h4400);
    checks++;
    if (result_ready !== 1'b1 || avg_pool_result !== 16'h4000) begin
      errors++; $display("FAIL midreset_before: got ready=%b %h want ready=1 4000", result_ready, avg_pool_result);
    end
    drive(16'h4400);
    do_reset();
    checks++;
    if (result_ready !== 1'b0 || avg_pool_result !== 16'h0000) begin
      errors++; $display("FAIL midreset_cleared: got ready=%b %h want ready=0 0000", result_ready, avg_pool_result);
    end
    for (int i = 0; i < 4; i++) drive(16'h3c00);
    checks++;
    if (result_ready !== 1'b0) begin
      errors++; $display("FAIL midreset_pending: ready got %b want 0", result_ready);
    end
    drive(16'h0000);
    checks++;
    if (result_ready !== 1'b1 || avg_pool_result !== 16'h3c00) begin
      errors++; $display("FAIL midreset_after: got ready=%b %h want ready=1 3c00", result_ready, avg_pool_result);
    end
  endtask

  // NaN, infinities, overflow to inf, subnormal-as-zero.
  task automatic test_specials();
    logic [15:0] vec [6][3];
    logic [7:0]  n   [6];
    logic [15:0] exp_v [6];
    vec[0] = '{16'h3c00, 16'h7c01, 16'h3c00}; n[0] = 8'd3; exp_v[0] = 16'h7e00;
    vec[1] = '{16'h7c00, 16'h3c00, 16'hc000}; n[1] = 8'd3; exp_v[1] = 16'h7c00;
    vec[2] = '{16'h7c00, 16'hfc00, 16'h3c00}; n[2] = 8'd3; exp_v[2] = 16'h7e00;
    vec[3] = '{16'hfc00, 16'h3c00, 16'h0000}; n[3] = 8'd2; exp_v[3] = 16'hfc00;
    vec[4] = '{16'h7bff, 16'h7bff, 16'h0000}; n[4] = 8'd2; exp_v[4] = 16'h7c00;
    vec[5] = '{16'h0001, 16'h3c00, 16'h0000}; n[5] = 8'd2; exp_v[5] = 16'h3800;
    for (int t = 0; t < 6; t++) begin
      do_reset();
      data_num = n[t];
      for (int i = 0; i < int'(n[t]); i++) drive(vec[t][i]);
      drive(16'h0000);
      checks++;
      if (result_ready !== 1'b1 || avg_pool_result !== exp_v[t]) begin
        errors++;
        $display("FAIL special[%0d]: got ready=%b %h want ready=1 %h",
                 t, result_ready, avg_pool_result, exp_v[t]);
      end
    end
  endtask

  // data_num=1 (and 0, treated as 1): each sample passes through one cycle later.
  task automatic test_single_sample();
    logic [15:0] seq [7];
    seq = '{16'h3c00, 16'hc000, 16'h4500, 16'h0000, 16'h4200, 16'hbc00, 16'h0000};
    do_reset();
    data_num = 8'd1;
    drive(seq[0]);
    checks++;
    if (result_ready !== 1'b0) begin
      errors++; $display("FAIL single_latency: ready got %b want 0", result_ready);
    end
    for (int i = 1; i < 7; i++) begin
      if (i == 4) data_num = 8'd0;
      drive(seq[i]);
      checks++;
      if (result_ready !== 1'b1 || avg_pool_result !== seq[i-1]) begin
        errors++;
        $display("FAIL single_pass[%0d]: got ready=%b %h want ready=1 %h",
                 i, result_ready, avg_pool_result, seq[i-1]);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    avg_input_data = 16'h0000;
    data_num = 8'd0;
    @(negedge clk);
    test_reset();
    test_constant_window();
    test_mean_patterns();
    test_back_to_back();
    test_data_num_change();
    test_reset_mid_window();
    test_specials();
    test_single_sample();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/avg_pool_unit_float16.md
Name: avg_pool_unit_float16

Overview:
- Streaming FP16 (IEEE binary16) average-pooling unit. It takes one scalar sample per clock and averages each window of data_num consecutive samples.
- Emits the mean as FP16, with a sticky ready flag.
- Instantiated once per parallel pooling lane; all lanes share clock, reset and data_num.

Parameters:
- DATA_WIDTH, 16, sample/result width (binary16; only 16 supported).
- DATA_NUM_WIDTH, 8, width of data_num; max window 255 (covers up to 15x15 pools).

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, synchronous active-low reset (0: reset; 1: run).
- avg_input_data, input, DATA_WIDTH, FP16 sample, captured every clk edge while rst=1.
- data_num, input, DATA_NUM_WIDTH, window length (pool_size*pool_size), unsigned.
- result_ready, output, 1, 1: avg_pool_result holds a valid average; 0: none yet.
- avg_pool_result, output, DATA_WIDTH, FP16 mean of the most recently completed window.

Behaviour:
- Reset (rst=0 at rising edge):
  - acc=0, count=0, result_ready=0, avg_pool_result=16'h0000, pipeline registers cleared.
  - Reset asserted mid-window discards the partial window.
- Sampling:
  - Every rising edge with rst=1 consumes exactly one sample; there is no valid/stall input.
  - First edge after rst rises is sample 1 of a window.
- Window length:
  - data_num is latched at sample 1 of each window (n_lat).
  - Changes to data_num mid-window take effect at the next window.
  - data_num=0 is treated as 1.
- Accumulation:
  - At sample 1, acc = x.
  - Otherwise acc = fp16_add(acc, x); count increments.
- Window completion (count == n_lat-1 at the edge):
  - Register the final sum S = fp16_add(acc, x) (or x if n_lat=1) and n_lat into the divide stage.
  - Reset count so the very next edge is sample 1 of a new window, with no bubble.
- Divide stage:
  - On the following edge, avg_pool_result <= fp16_div(S, fp16(n_lat)) and result_ready <= 1.
  - Latency: result visible 1 cycle after the edge capturing the last sample.
- Ready and result holding:
  - result_ready is sticky: it stays 1 until reset, including across subsequent windows.
  - avg_pool_result holds until the next window completes.
- fp16_add:
  - Align, add/subtract, normalize, round-to-nearest-even.
  - Subnormal inputs are treated as zero; subnormal results flush to +0.
  - Exact zero result is +0.
  - Overflow gives ±inf (exp=31, mant=0).
- fp16_div:
  - n_lat is converted exactly to FP16 (all 1..255 exact).
  - Mantissa division produces ≥13 quotient bits plus sticky; round-to-nearest-even; sign passes from S.
  - Same subnormal flush and overflow rules as fp16_add.
  - S=±0 gives +0.
- Specials:
  - Any NaN in a window gives result 16'h7E00.
  - Inf in a window gives ±inf, unless +inf and -inf are both present, which gives 16'h7E00.
  - inf/n gives inf.
- Implementation constraints:
  - Single-cycle combinational adder and divider between registers; no multicycle paths.
  - Full-window timing is deterministic: result after n_lat+1 edges from window start.

Test Plan:
- Reset then 9 samples of 16'h4200 (3.0), data_num=9 → 1 cycle after 9th sample: result_ready=1, avg_pool_result=16'h4200. Same with 16'h3C00 gives 16'h3C00; 16'h4000 gives 16'h4000.
- Reset, data_num=4, samples 3C00,4200,3C00,4200 (1,3,1,3) → 16'h4000. Samples 4000,4400,4400,4000 → 16'h4200.
- Back-to-back windows, data_num=4: four 16'h4000 then four 16'h4400 → result 16'h4000 then 16'h4400 four cycles later; result_ready never drops.
- Negative/fractional, data_num=4: BC00,BC00,3C00,4200 (-1,-1,1,3) → 16'h3800 (0.5). data_num=3 with three 3C00 → 16'h3C00 (exact 3/3).
- data_num changed from 4 to 2 at sample 2 → current window still closes after 4 samples; next window closes after 2.
- Reset pulse after 2 of 4 samples → result_ready=0, result=0; the following 4 samples of 16'h3C00 give 16'h3C00. Also: NaN sample 16'h7C01 in a window gives 16'h7E00; data_num=1 passes each sample through with 1-cycle latency.
